vga_timing_gen: RTL and testbench
=================================

// Module: vga_timing_gen
// PURPOSE
// Parametrised VGA/DVI raster timing generator. It succeeds the fixed-mode 640x480 driver.
// - Timing, sync polarity and colour depth are all parameters.
// - A pixel-clock enable lets it run on a faster system clock.
// - A request interface leads the display by LEAD ticks so a framebuffer or pattern source can fetch ahead.
// - The sync/DE/RGB outputs are registered and mutually aligned.
// Sits between the pattern/framebuffer logic and the board VGA pins.
// PARAMETERS
// H_ACTIVE  640  visible pixels per line
// H_FRONT   16   horizontal front porch, pixel ticks
// H_PULSE   96   hsync width, pixel ticks
// H_BACK    48   horizontal back porch, pixel ticks
// V_ACTIVE  480  visible lines per frame
// V_FRONT   10   vertical front porch, lines
// V_PULSE   2    vsync width, lines
// V_BACK    33   vertical back porch, lines
// H_POL     0    hsync active level (0 = active-low, 1 = active-high)
// V_POL     0    vsync active level
// CW        11   h/v counter and coordinate width; must hold H_TOTAL-1 and V_TOTAL-1
// RW,GW,BW  3,3,2  red/green/blue output widths
// LEAD      2    pipeline lead (1..8 pixel ticks) from req to the pixel appearing on red/green/blue
// PORTS
// clk          in   1         system clock
// rst          in   1         asynchronous, active-high reset
// pix_en       in   1         pixel-tick enable; all state advances only when 1
// color        in   RW+GW+BW  pixel for the request issued LEAD ticks earlier, {r,g,b} MSB-first
// req          out  1         current counter position is visible; source must fetch (req_x,req_y)
// req_x,req_y  out  CW        coordinate being requested (0 when req=0)
// line_start   out  1         1 for the tick where h==0 && v<V_ACTIVE (counter stage)
// frame_start  out  1         1 for the tick where h==0 && v==0 (counter stage)
// frame_count  out  16        completed frames, wraps 0xFFFF->0
// hsync,vsync  out  1         registered syncs, polarity per H_POL/V_POL
// de           out  1         registered display enable, aligned with RGB
// red,green,blue out RW/GW/BW registered colour, forced 0 when de=0
// BEHAVIOUR
// - H_TOTAL = H_ACTIVE+H_FRONT+H_PULSE+H_BACK; V_TOTAL is defined likewise.
// - Counters, on each tick with pix_en=1:
//   - h increments; at h==H_TOTAL-1, h goes to 0 and v increments.
//   - At (H_TOTAL-1, V_TOTAL-1), both go to 0 and frame_count increments.
// - pix_en=0: counters, pipeline, outputs and frame_count all hold. req/line_start/frame_start are gated to 0.
// - Counter stage (combinational from h,v), gated by pix_en:
//   - req = (h<H_ACTIVE && v<V_ACTIVE); req_x = h, req_y = v while req, else 0.
// - Sync windows are inclusive start, exclusive end:
//   - hs_act = H_ACTIVE+H_FRONT <= h < H_ACTIVE+H_FRONT+H_PULSE.
//   - vs_act = V_ACTIVE+V_FRONT <= v < V_ACTIVE+V_FRONT+V_PULSE.
//   - vs_act is evaluated per line and is independent of h.
// - Output pipeline:
//   - {hs_act, vs_act, req} pass through a LEAD-deep shift register clocked on pix_en.
//   - Final register: hsync = hs_d ^ ~H_POL, vsync = vs_d ^ ~V_POL, de = req_d.
//   - red/green/blue = de_next ? color slices : 0.
//   - Net effect: the pixel requested at tick T appears on the pins at tick T+LEAD. color is sampled at tick T+LEAD-1.
// - Reset (async; every value is also held while rst=1):
//   - h=v=0, pipeline cleared to inactive, frame_count=0, de=0, RGB=0.
//   - hsync = ~H_POL and vsync = ~V_POL (deasserted).
// - Reset mid-frame: outputs go inactive immediately. The first tick after release is (0,0) with frame_start=1.
// - frame_start and line_start coincide on line 0. Neither is asserted on lines v>=V_ACTIVE.
// - x/y never exceed the active area; no out-of-range coordinate is ever requested.
// TESTING
// - Defaults, pix_en=1:
//   - frame = 420000 ticks; frame_start period 420000.
//   - hsync low for exactly 96 ticks, starting LEAD ticks after h=656.
//   - vsync low for exactly 2 lines (1600 ticks).
// - Defaults, color=req_x[7:0] looped back with LEAD delay: red/green/blue at pin tick T+2 equal the slices of x requested at tick T; de high 640 ticks/line, 480 lines.
// - H=8/2/3/2, V=4/1/1/1, H_POL=V_POL=1, pix_en toggling 1,0,1,0:
//   - H_TOTAL=15 ticks/line, 105 ticks/frame; nothing changes on pix_en=0 cycles.
//   - hsync high at h=10..12 (+LEAD); vsync high on line 5 only.
// - Assert rst at h=300, v=200 for 3 clocks:
//   - outputs inactive within the same cycle (async) and frame_count=0.
//   - after release, frame_start=1 with req_x=req_y=0.
// - Force frame_count to 0xFFFF, run one frame -> frame_count=0x0000, no glitch on other outputs.
// - LEAD=1 and LEAD=8 builds: pipeline-alignment check of de vs req (delay exactly LEAD ticks); RGB=0 whenever de=0.

Source files
------------

// File: rtl/vga_timing_gen.sv
// Parametrised VGA/DVI raster timing generator: h/v counters, a request port that
// leads the display by LEAD pixel ticks, and registered, mutually aligned sync/DE/RGB.
module vga_timing_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FRONT  = 16,
    parameter int H_PULSE  = 96,
    parameter int H_BACK   = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FRONT  = 10,
    parameter int V_PULSE  = 2,
    parameter int V_BACK   = 33,
    parameter bit H_POL    = 1'b0,
    parameter bit V_POL    = 1'b0,
    parameter int CW       = 11,
    parameter int RW       = 3,
    parameter int GW       = 3,
    parameter int BW       = 2,
    parameter int LEAD     = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                pix_en,
    input  logic [RW+GW+BW-1:0] color,
    output logic                req,
    output logic [CW-1:0]       req_x,
    output logic [CW-1:0]       req_y,
    output logic                line_start,
    output logic                frame_start,
    output logic [15:0]         frame_count,
    output logic                hsync,
    output logic                vsync,
    output logic                de,
    output logic [RW-1:0]       red,
    output logic [GW-1:0]       green,
    output logic [BW-1:0]       blue
);

    localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_PULSE + H_BACK;
    localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_PULSE + V_BACK;
    localparam int CFW     = RW + GW + BW;

    localparam logic [CW-1:0] H_LAST = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_LAST = CW'(V_TOTAL - 1);

    // One extra bit so window ends equal to the line/frame total cannot wrap.
    localparam logic [CW:0] H_VIS  = (CW+1)'(H_ACTIVE);
    localparam logic [CW:0] V_VIS  = (CW+1)'(V_ACTIVE);
    localparam logic [CW:0] HS_BEG = (CW+1)'(H_ACTIVE + H_FRONT);
    localparam logic [CW:0] HS_END = (CW+1)'(H_ACTIVE + H_FRONT + H_PULSE);
    localparam logic [CW:0] VS_BEG = (CW+1)'(V_ACTIVE + V_FRONT);
    localparam logic [CW:0] VS_END = (CW+1)'(V_ACTIVE + V_FRONT + V_PULSE);

    logic [CW-1:0]  h_q, h_d;
    logic [CW-1:0]  v_q, v_d;
    logic [15:0]    frame_count_q, frame_count_d;
    logic           hsync_q, hsync_d;
    logic           vsync_q, vsync_d;
    logic           de_q, de_d;
    logic [RW-1:0]  red_q, red_d;
    logic [GW-1:0]  green_q, green_d;
    logic [BW-1:0]  blue_q, blue_d;

    logic [CW:0]    h_ext, v_ext;
    logic           vis, hs_act, vs_act;
    logic [2:0]     stage_in;   // {hs_act, vs_act, vis}
    logic [2:0]     tail;       // stage_in delayed by LEAD-1 ticks

    // NOTE: every combinational output gets a default first, so no path leaves it unassigned (no latch).
    always_comb begin
        h_d           = h_q;
        v_d           = v_q;
        frame_count_d = frame_count_q;
        if (pix_en) begin
            if (h_q == H_LAST) begin
                h_d = '0;
                if (v_q == V_LAST) begin
                    v_d           = '0;
                    frame_count_d = frame_count_q + 16'd1;
                end else begin
                    v_d = v_q + 1'b1;
                end
            end else begin
                h_d = h_q + 1'b1;
            end
        end
    end

    assign h_ext    = {1'b0, h_q};
    assign v_ext    = {1'b0, v_q};
    assign vis      = (h_ext < H_VIS) && (v_ext < V_VIS);
    assign hs_act   = (h_ext >= HS_BEG) && (h_ext < HS_END);
    assign vs_act   = (v_ext >= VS_BEG) && (v_ext < VS_END);
    assign stage_in = {hs_act, vs_act, vis};

    assign req         = pix_en && vis;
    assign req_x       = req ? h_q : '0;
    assign req_y       = req ? v_q : '0;
    assign line_start  = pix_en && (h_q == '0) && (v_ext < V_VIS);
    assign frame_start = pix_en && (h_q == '0) && (v_q == '0);

    // The output register is the last of the LEAD stages, so only LEAD-1 sit in front of it.
    if (LEAD == 1) begin : g_no_pipe
        assign tail = stage_in;
    end else begin : g_pipe
        logic [2:0] pipe_q [LEAD-1];
        logic [2:0] pipe_d [LEAD-1];

        always_comb begin
            pipe_d = pipe_q;
            if (pix_en) begin
                pipe_d[0] = stage_in;
                for (int i = 1; i < LEAD - 1; i++) begin
                    pipe_d[i] = pipe_q[i-1];
                end
            end
        end

        // NOTE: this small shift register is reset, unlike a RAM, so no stale sync/DE leaks out after reset.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                for (int i = 0; i < LEAD - 1; i++) begin
                    pipe_q[i] <= '0;
                end
            end else begin
                pipe_q <= pipe_d;
            end
        end

        assign tail = pipe_q[LEAD-2];
    end

    always_comb begin
        hsync_d = hsync_q;
        vsync_d = vsync_q;
        de_d    = de_q;
        red_d   = red_q;
        green_d = green_q;
        blue_d  = blue_q;
        if (pix_en) begin
            hsync_d = tail[2] ? H_POL : ~H_POL;
            vsync_d = tail[1] ? V_POL : ~V_POL;
            de_d    = tail[0];
            red_d   = tail[0] ? color[CFW-1 -: RW]   : '0;
            green_d = tail[0] ? color[GW+BW-1 -: GW] : '0;
            blue_d  = tail[0] ? color[BW-1:0]        : '0;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            h_q           <= '0;
            v_q           <= '0;
            frame_count_q <= '0;
            hsync_q       <= ~H_POL;
            vsync_q       <= ~V_POL;
            de_q          <= 1'b0;
            red_q         <= '0;
            green_q       <= '0;
            blue_q        <= '0;
        end else begin
            h_q           <= h_d;
            v_q           <= v_d;
            frame_count_q <= frame_count_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            de_q          <= de_d;
            red_q         <= red_d;
            green_q       <= green_d;
            blue_q        <= blue_d;
        end
    end

    assign frame_count = frame_count_q;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign de          = de_q;
    assign red         = red_q;
    assign green       = green_q;
    assign blue        = blue_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Self-checking bench for vga_timing_gen: four builds (default, small with active-high
// syncs, LEAD=1, LEAD=8) compared against a tick-count raster model.
`timescale 1ns/1ps
module tb_vga_timing_gen;

    typedef struct packed {
        int ha; int hf; int hp; int hb;
        int va; int vf; int vp; int vb;
        bit hpol; bit vpol; int lead;
    } cfg_t;

    typedef struct packed {
        bit req; int x; int y; bit ls; bit fs;
        bit hs; bit vs; bit de; int px;
    } exp_t;

    localparam cfg_t C_DEF = '{640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0, 2};
    localparam cfg_t C_SML = '{8, 2, 3, 2, 4, 1, 1, 1, 1'b1, 1'b1, 2};
    localparam cfg_t C_L1  = '{6, 1, 2, 1, 3, 1, 1, 1, 1'b0, 1'b0, 1};
    localparam cfg_t C_L8  = '{6, 1, 2, 1, 3, 1, 1, 1, 1'b0, 1'b0, 8};

    logic        clk = 1'b0;
    logic        rst;
    logic        pix_en;
    logic [11:0] col;
    logic [11:0] col_smp;
    logic [7:0]  lb_q;
    int          n = 0;
    int          fc_base = 0;
    int          n_cmp = 0;
    int          n_bad = 0;

    always #5 clk = ~clk;

    logic d_req, d_ls, d_fs, d_hs, d_vs, d_de;
    logic [10:0] d_x, d_y; logic [15:0] d_fc; logic [2:0] d_r, d_g; logic [1:0] d_b;
    logic s_req, s_ls, s_fs, s_hs, s_vs, s_de;
    logic [10:0] s_x, s_y; logic [15:0] s_fc; logic [3:0] s_r, s_g, s_b;
    logic a_req, a_ls, a_fs, a_hs, a_vs, a_de;
    logic [10:0] a_x, a_y; logic [15:0] a_fc; logic [2:0] a_r, a_g; logic [1:0] a_b;
    logic e_req, e_ls, e_fs, e_hs, e_vs, e_de;
    logic [10:0] e_x, e_y; logic [15:0] e_fc; logic [2:0] e_r, e_g; logic [1:0] e_b;

    vga_timing_gen dut_d (
        .clk(clk), .rst(rst), .pix_en(pix_en), .color(lb_q),
        .req(d_req), .req_x(d_x), .req_y(d_y), .line_start(d_ls), .frame_start(d_fs),
        .frame_count(d_fc), .hsync(d_hs), .vsync(d_vs), .de(d_de),
        .red(d_r), .green(d_g), .blue(d_b));

    vga_timing_gen #(
        .H_ACTIVE(8), .H_FRONT(2), .H_PULSE(3), .H_BACK(2),
        .V_ACTIVE(4), .V_FRONT(1), .V_PULSE(1), .V_BACK(1),
        .H_POL(1'b1), .V_POL(1'b1), .RW(4), .GW(4), .BW(4), .LEAD(2)
    ) dut_s (
        .clk(clk), .rst(rst), .pix_en(pix_en), .color(col),
        .req(s_req), .req_x(s_x), .req_y(s_y), .line_start(s_ls), .frame_start(s_fs),
        .frame_count(s_fc), .hsync(s_hs), .vsync(s_vs), .de(s_de),
        .red(s_r), .green(s_g), .blue(s_b));

    vga_timing_gen #(
        .H_ACTIVE(6), .H_FRONT(1), .H_PULSE(2), .H_BACK(1),
        .V_ACTIVE(3), .V_FRONT(1), .V_PULSE(1), .V_BACK(1), .LEAD(1)
    ) dut_a (
        .clk(clk), .rst(rst), .pix_en(pix_en), .color(col[7:0]),
        .req(a_req), .req_x(a_x), .req_y(a_y), .line_start(a_ls), .frame_start(a_fs),
        .frame_count(a_fc), .hsync(a_hs), .vsync(a_vs), .de(a_de),
        .red(a_r), .green(a_g), .blue(a_b));

    vga_timing_gen #(
        .H_ACTIVE(6), .H_FRONT(1), .H_PULSE(2), .H_BACK(1),
        .V_ACTIVE(3), .V_FRONT(1), .V_PULSE(1), .V_BACK(1), .LEAD(8)
    ) dut_e (
        .clk(clk), .rst(rst), .pix_en(pix_en), .color(col[7:0]),
        .req(e_req), .req_x(e_x), .req_y(e_y), .line_start(e_ls), .frame_start(e_fs),
        .frame_count(e_fc), .hsync(e_hs), .vsync(e_vs), .de(e_de),
        .red(e_r), .green(e_g), .blue(e_b));

    // Pixel ticks since reset release, and the colour each build sampled on the last tick.
    always @(posedge clk or posedge rst) begin
        if (rst) n <= 0;
        else if (pix_en) n <= n + 1;
    end

    always @(posedge clk) begin
        if (pix_en) begin
            col_smp <= col;
            lb_q    <= d_x[7:0];
        end
    end

    function automatic int frame_ticks(cfg_t c);
        return (c.ha + c.hf + c.hp + c.hb) * (c.va + c.vf + c.vp + c.vb);
    endfunction

    // Raster position is a pure function of the tick index; pins show the position LEAD ticks back.
    function automatic exp_t model(cfg_t c, int t, bit pe);
        exp_t e;
        int ht, vt, h, v, m, hm, vm;
        ht = c.ha + c.hf + c.hp + c.hb;
        vt = c.va + c.vf + c.vp + c.vb;
        h  = t % ht;
        v  = (t / ht) % vt;
        e.req = pe && (h < c.ha) && (v < c.va);
        e.x   = e.req ? h : 0;
        e.y   = e.req ? v : 0;
        e.ls  = pe && (h == 0) && (v < c.va);
        e.fs  = pe && (h == 0) && (v == 0);
        e.hs  = !c.hpol;
        e.vs  = !c.vpol;
        e.de  = 1'b0;
        e.px  = 0;
        if (t >= c.lead) begin
            m  = t - c.lead;
            hm = m % ht;
            vm = (m / ht) % vt;
            if (hm >= c.ha + c.hf && hm < c.ha + c.hf + c.hp) e.hs = c.hpol;
            if (vm >= c.va + c.vf && vm < c.va + c.vf + c.vp) e.vs = c.vpol;
            e.de = (hm < c.ha) && (vm < c.va);
            e.px = e.de ? hm : 0;
        end
        return e;
    endfunction

    task automatic test_reset();
        rst = 1'b1; pix_en = 1'b1; col = '0; fc_base = 0;
        repeat (3) @(negedge clk);
        #1;
        n_cmp++;
        if ({d_hs, d_vs, d_de, d_r, d_g, d_b} !== {3'b110, 8'h00}) begin
            n_bad++; $display("FAIL reset_def got=%h exp=%h", {d_hs, d_vs, d_de, d_r, d_g, d_b}, {3'b110, 8'h00});
        end
        n_cmp++;
        if ({s_hs, s_vs, s_de, s_r, s_g, s_b} !== 15'h0) begin
            n_bad++; $display("FAIL reset_small got=%h exp=0", {s_hs, s_vs, s_de, s_r, s_g, s_b});
        end
        n_cmp++;
        if ({a_hs, a_vs, a_de, a_r, a_g, a_b, e_hs, e_vs, e_de, e_r, e_g, e_b} !== {3'b110, 8'h00, 3'b110, 8'h00}) begin
            n_bad++; $display("FAIL reset_lead got=%h", {a_hs, a_vs, a_de, a_r, a_g, a_b, e_hs, e_vs, e_de, e_r, e_g, e_b});
        end
        n_cmp++;
        if ({d_fc, s_fc, a_fc, e_fc} !== 64'h0) begin
            n_bad++; $display("FAIL reset_fc got=%h exp=0", {d_fc, s_fc, a_fc, e_fc});
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_cmp++;
        if ({d_req, d_fs, d_ls, d_x, d_y, s_fs, s_ls} !== {3'b111, 22'h0, 2'b11}) begin
            n_bad++; $display("FAIL first_tick got req/fs/ls=%b x=%0d y=%0d small fs/ls=%b",
                              {d_req, d_fs, d_ls}, d_x, d_y, {s_fs, s_ls});
        end
    endtask

    task automatic test_def_lines();
        exp_t e;
        int lo_len, lo_start, de_cnt;
        lo_len = 0; lo_start = 0; de_cnt = 0;
        for (int k = 0; k < 1601; k++) begin
            @(negedge clk);
            pix_en = 1'b1;
            #1;
            e = model(C_DEF, n, pix_en);
            n_cmp++;
            if ({d_req, d_x, d_y, d_ls, d_fs} !== {e.req, 11'(e.x), 11'(e.y), e.ls, e.fs}) begin
                n_bad++; $display("FAIL def_req n=%0d got req=%b x=%0d y=%0d ls=%b fs=%b exp req=%b x=%0d y=%0d ls=%b fs=%b",
                                  n, d_req, d_x, d_y, d_ls, d_fs, e.req, e.x, e.y, e.ls, e.fs);
            end
            n_cmp++;
            if ({d_hs, d_vs, d_de} !== {e.hs, e.vs, e.de}) begin
                n_bad++; $display("FAIL def_sync n=%0d got=%b exp=%b", n, {d_hs, d_vs, d_de}, {e.hs, e.vs, e.de});
            end
            n_cmp++;
            if ({d_r, d_g, d_b} !== (e.de ? 8'(e.px) : 8'h00)) begin
                n_bad++; $display("FAIL def_rgb n=%0d got=%h exp=%h", n, {d_r, d_g, d_b}, e.de ? 8'(e.px) : 8'h00);
            end
            if (d_de === 1'b1) de_cnt++;
            if (d_hs === 1'b0) begin
                if (lo_len == 0) lo_start = n;
                lo_len++;
            end else if (lo_len > 0) begin
                n_cmp++;
                if (lo_len != 96 || (lo_start % 800) != 656 + 2) begin
                    n_bad++; $display("FAIL def_hsync_run got len=%0d start_h=%0d exp len=96 start_h=658", lo_len, lo_start % 800);
                end
                lo_len = 0;
            end
        end
        n_cmp++;
        if (de_cnt != 1280) begin
            n_bad++; $display("FAIL def_de_count got=%0d exp=1280", de_cnt);
        end
    endtask

    task automatic test_small_toggle();
        exp_t e;
        for (int k = 0; k < 620; k++) begin
            @(negedge clk);
            pix_en = (k < 420) ? (k % 2 == 0) : ($urandom_range(0, 2) != 0);
            col = 12'($urandom);
            #1;
            e = model(C_SML, n, pix_en);
            n_cmp++;
            if ({s_req, s_x, s_y, s_ls, s_fs} !== {e.req, 11'(e.x), 11'(e.y), e.ls, e.fs}) begin
                n_bad++; $display("FAIL small_req n=%0d pe=%b got req=%b x=%0d y=%0d ls=%b fs=%b exp req=%b x=%0d y=%0d ls=%b fs=%b",
                                  n, pix_en, s_req, s_x, s_y, s_ls, s_fs, e.req, e.x, e.y, e.ls, e.fs);
            end
            n_cmp++;
            if ({s_hs, s_vs, s_de} !== {e.hs, e.vs, e.de}) begin
                n_bad++; $display("FAIL small_sync n=%0d got=%b exp=%b", n, {s_hs, s_vs, s_de}, {e.hs, e.vs, e.de});
            end
            n_cmp++;
            if ({s_r, s_g, s_b} !== (e.de ? col_smp : 12'h000)) begin
                n_bad++; $display("FAIL small_rgb n=%0d got=%h exp=%h", n, {s_r, s_g, s_b}, e.de ? col_smp : 12'h000);
            end
            n_cmp++;
            if (s_fc !== 16'((fc_base + n / frame_ticks(C_SML)) % 65536)) begin
                n_bad++; $display("FAIL small_fc n=%0d got=%0d exp=%0d", n, s_fc, (fc_base + n / frame_ticks(C_SML)) % 65536);
            end
        end
    endtask

    task automatic test_lead();
        exp_t ea, ee;
        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            pix_en = ($urandom_range(0, 3) != 0);
            col = 12'($urandom);
            #1;
            ea = model(C_L1, n, pix_en);
            ee = model(C_L8, n, pix_en);
            n_cmp++;
            if ({a_req, a_hs, a_vs, a_de} !== {ea.req, ea.hs, ea.vs, ea.de}) begin
                n_bad++; $display("FAIL lead1_align n=%0d got=%b exp=%b", n, {a_req, a_hs, a_vs, a_de}, {ea.req, ea.hs, ea.vs, ea.de});
            end
            n_cmp++;
            if ({e_req, e_hs, e_vs, e_de} !== {ee.req, ee.hs, ee.vs, ee.de}) begin
                n_bad++; $display("FAIL lead8_align n=%0d got=%b exp=%b", n, {e_req, e_hs, e_vs, e_de}, {ee.req, ee.hs, ee.vs, ee.de});
            end
            n_cmp++;
            if ({a_r, a_g, a_b, e_r, e_g, e_b} !== {(ea.de ? col_smp[7:0] : 8'h00), (ee.de ? col_smp[7:0] : 8'h00)}) begin
                n_bad++; $display("FAIL lead_rgb n=%0d got=%h exp=%h", n, {a_r, a_g, a_b, e_r, e_g, e_b},
                                  {(ea.de ? col_smp[7:0] : 8'h00), (ee.de ? col_smp[7:0] : 8'h00)});
            end
        end
    endtask

    task automatic test_mid_reset();
        exp_t e;
        int k;
        pix_en = 1'b1;
        k = 0;
        do begin
            @(negedge clk);
            pix_en = 1'b1;
            #1;
            k++;
        end while ((n % 800) != 300 && k < 900);
        e = model(C_DEF, n, pix_en);
        n_cmp++;
        if ({d_x, d_de} !== {11'(e.x), e.de} || (n % 800) != 300) begin
            n_bad++; $display("FAIL mid_pre got x=%0d de=%b exp x=%0d de=%b", d_x, d_de, e.x, e.de);
        end
        #2 rst = 1'b1;
        #1;
        n_cmp++;
        if ({d_hs, d_vs, d_de, d_r, d_g, d_b, d_fc} !== {3'b110, 8'h00, 16'h0000}) begin
            n_bad++; $display("FAIL mid_async_def got=%h", {d_hs, d_vs, d_de, d_r, d_g, d_b, d_fc});
        end
        n_cmp++;
        if ({s_hs, s_vs, s_de, s_r, s_g, s_b, s_fc} !== 31'h0) begin
            n_bad++; $display("FAIL mid_async_small got=%h exp=0", {s_hs, s_vs, s_de, s_r, s_g, s_b, s_fc});
        end
        repeat (3) @(negedge clk);
        #1;
        n_cmp++;
        if ({d_hs, d_vs, d_de, d_r, d_g, d_b, d_fc} !== {3'b110, 8'h00, 16'h0000}) begin
            n_bad++; $display("FAIL mid_hold_def got=%h", {d_hs, d_vs, d_de, d_r, d_g, d_b, d_fc});
        end
        rst = 1'b0;
        fc_base = 0;
        #1;
        n_cmp++;
        if ({d_req, d_fs, d_x, d_y, s_fs} !== {2'b11, 22'h0, 1'b1}) begin
            n_bad++; $display("FAIL mid_release got req=%b fs=%b x=%0d y=%0d small_fs=%b exp 1 1 0 0 1",
                              d_req, d_fs, d_x, d_y, s_fs);
        end
    endtask

    task automatic test_frame_wrap();
        exp_t e;
        int target, k;
        @(negedge clk);
        pix_en = 1'b0;
        force dut_s.frame_count_q = 16'hFFFF;
        @(negedge clk);
        release dut_s.frame_count_q;
        fc_base = 65535 - n / frame_ticks(C_SML);
        target = (n / frame_ticks(C_SML) + 1) * frame_ticks(C_SML);
        #1;
        n_cmp++;
        if (s_fc !== 16'hFFFF) begin
            n_bad++; $display("FAIL wrap_preload got=%h exp=ffff", s_fc);
        end
        k = 0;
        while (n < target && k < 250) begin
            @(negedge clk);
            pix_en = 1'b1;
            col = 12'($urandom);
            #1;
            k++;
            e = model(C_SML, n, pix_en);
            n_cmp++;
            if ({s_hs, s_vs, s_de, s_r, s_g, s_b} !== {e.hs, e.vs, e.de, (e.de ? col_smp : 12'h000)}) begin
                n_bad++; $display("FAIL wrap_outputs n=%0d got=%h exp=%h", n, {s_hs, s_vs, s_de, s_r, s_g, s_b},
                                  {e.hs, e.vs, e.de, (e.de ? col_smp : 12'h000)});
            end
            n_cmp++;
            if (s_fc !== 16'((fc_base + n / frame_ticks(C_SML)) % 65536)) begin
                n_bad++; $display("FAIL wrap_fc n=%0d got=%h exp=%h", n, s_fc, 16'((fc_base + n / frame_ticks(C_SML)) % 65536));
            end
        end
        n_cmp++;
        if (s_fc !== 16'h0000 || n != target) begin
            n_bad++; $display("FAIL wrap_final got fc=%h at n=%0d exp fc=0000 at n=%0d", s_fc, n, target);
        end
    endtask

    initial begin
        rst = 1'b1;
        pix_en = 1'b0;
        col = '0;
        test_reset();
        test_def_lines();
        test_small_toggle();
        test_lead();
        test_mid_reset();
        test_frame_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "simulation time limit reached");
    end

endmodule
